// File: rtl/simple_processor_pkg.sv
// Shared types for the simple processor ALU: operation encodings, result flags
// and the multi-cycle ALU state enum.
package simple_processor_pkg;

   localparam int unsigned FUNC_WIDTH = 3;

   // Encodings 4..7 are unused and reported as invalid requests.
   typedef enum logic [FUNC_WIDTH-1:0] {
      FUNC_ADD  = 3'd0,
      FUNC_ADDI = 3'd1,
      FUNC_SUB  = 3'd2,
      FUNC_MUL  = 3'd3
   } func_t;

   typedef struct packed {
      logic zero;
      logic carry;
      logic overflow;
   } alu_flags_t;

   typedef enum logic {
      IDLE     = 1'b0,
      MUL_BUSY = 1'b1
   } alu_mc_state_t;

   localparam alu_flags_t INVALID_FLAGS = '{zero: 1'b1, carry: 1'b0, overflow: 1'b0};

   function automatic logic is_addsub(input func_t f);
      return (f == FUNC_ADD) || (f == FUNC_ADDI) || (f == FUNC_SUB);
   endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative unsigned shift-add multiplier: one multiplier bit per cycle,
// DATA_WIDTH iterations after start, then a one-cycle done pulse.
module alu_mul_iter #(
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    start,
   input  logic [DATA_WIDTH-1:0]   op_a,
   input  logic [DATA_WIDTH-1:0]   op_b,
   output logic                    busy,
   output logic                    done,
   output logic [2*DATA_WIDTH-1:0] product
);

   localparam int unsigned CNT_WIDTH  = $clog2(DATA_WIDTH + 1);
   localparam int unsigned PROD_WIDTH = 2 * DATA_WIDTH;

   logic [PROD_WIDTH-1:0] mcand;
   logic [DATA_WIDTH-1:0] mplier;
   logic [CNT_WIDTH-1:0]  count;

   // Product accumulates in place; the multiplicand shifts left as the
   // multiplier is consumed LSB first.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         mcand   <= '0;
         mplier  <= '0;
         count   <= '0;
         product <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start) begin
            mcand   <= PROD_WIDTH'(op_a);
            mplier  <= op_b;
            product <= '0;
            count   <= '0;
            busy    <= 1'b1;
         end else if (busy) begin
            if (mplier[0]) begin
               product <= product + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + CNT_WIDTH'(1);
            if (count == CNT_WIDTH'(DATA_WIDTH - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/alu_math_mc.sv
// Multi-cycle handshaked math ALU: single-cycle ADD/ADDI/SUB, iterative MUL,
// registered result with zero/carry/overflow flags and an invalid-op error.
module alu_math_mc
   import simple_processor_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned IMM_WIDTH  = 6
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  valid_i,
   output logic                  ready_o,
   input  func_t                 func_i,
   input  logic [DATA_WIDTH-1:0] rs1_data_i,
   input  logic [DATA_WIDTH-1:0] rs2_data_i,
   input  logic [IMM_WIDTH-1:0]  imm_i,
   output logic                  valid_o,
   input  logic                  ready_i,
   output logic [DATA_WIDTH-1:0] result_o,
   output logic                  zero_o,
   output logic                  carry_o,
   output logic                  overflow_o,
   output logic                  err_o
);

   localparam int unsigned SUM_WIDTH = DATA_WIDTH + 1;
   localparam int unsigned EXT_WIDTH = DATA_WIDTH - IMM_WIDTH;

   alu_mc_state_t state;
   alu_flags_t    flags_q;

   logic                    accept;
   logic                    mul_start;
   logic                    mul_busy;
   logic                    mul_done;
   logic [2*DATA_WIDTH-1:0] mul_product;

   logic [DATA_WIDTH-1:0] imm_ext;
   logic [DATA_WIDTH-1:0] op_b;
   logic                  carry_in;
   logic [SUM_WIDTH-1:0]  sum;
   alu_flags_t            add_flags;
   alu_flags_t            mul_flags;

   assign ready_o   = (state == IDLE) && (!valid_o || ready_i);
   assign accept    = valid_i && ready_o;
   assign mul_start = accept && (func_i == FUNC_MUL);

   assign zero_o     = flags_q.zero;
   assign carry_o    = flags_q.carry;
   assign overflow_o = flags_q.overflow;

   assign imm_ext = {{EXT_WIDTH{imm_i[IMM_WIDTH-1]}}, imm_i};

   // Shared adder: SUB is rs1 + ~rs2 + 1 so carry-out means "no borrow".
   always_comb begin
      op_b     = rs2_data_i;
      carry_in = 1'b0;
      case (func_i)
         FUNC_ADDI: op_b = imm_ext;
         FUNC_SUB: begin
            op_b     = ~rs2_data_i;
            carry_in = 1'b1;
         end
         default: ;
      endcase
      sum = {1'b0, rs1_data_i} + {1'b0, op_b} + SUM_WIDTH'(carry_in);
      add_flags.zero     = (sum[DATA_WIDTH-1:0] == '0);
      add_flags.carry    = sum[DATA_WIDTH];
      add_flags.overflow = (rs1_data_i[DATA_WIDTH-1] == op_b[DATA_WIDTH-1]) &&
                           (sum[DATA_WIDTH-1] != rs1_data_i[DATA_WIDTH-1]);
   end

   // Product high half feeds both carry and overflow for the unsigned MUL.
   always_comb begin
      mul_flags.zero     = (mul_product[DATA_WIDTH-1:0] == '0);
      mul_flags.carry    = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
      mul_flags.overflow = |mul_product[2*DATA_WIDTH-1:DATA_WIDTH];
   end

   alu_mul_iter #(
      .DATA_WIDTH (DATA_WIDTH)
   ) u_mul (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .start   (mul_start),
      .op_a    (rs1_data_i),
      .op_b    (rs2_data_i),
      .busy    (mul_busy),
      .done    (mul_done),
      .product (mul_product)
   );

   // Control FSM and output register; a consumed result is dropped unless a
   // new one loads on the same edge.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state    <= IDLE;
         valid_o  <= 1'b0;
         result_o <= '0;
         flags_q  <= '0;
         err_o    <= 1'b0;
      end else begin
         if (valid_o && ready_i) begin
            valid_o <= 1'b0;
         end
         case (state)
            IDLE: begin
               if (accept) begin
                  if (func_i == FUNC_MUL) begin
                     state <= MUL_BUSY;
                  end else if (is_addsub(func_i)) begin
                     valid_o  <= 1'b1;
                     result_o <= sum[DATA_WIDTH-1:0];
                     flags_q  <= add_flags;
                     err_o    <= 1'b0;
                  end else begin
                     valid_o  <= 1'b1;
                     result_o <= '0;
                     flags_q  <= INVALID_FLAGS;
                     err_o    <= 1'b1;
                  end
               end
            end
            MUL_BUSY: begin
               if (mul_done && !mul_busy) begin
                  state    <= IDLE;
                  valid_o  <= 1'b1;
                  result_o <= mul_product[DATA_WIDTH-1:0];
                  flags_q  <= mul_flags;
                  err_o    <= 1'b0;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_alu_math_mc.sv
// Bench for alu_math_mc: directed scenarios with literal expectations plus a
// randomized request stream scored against a behavioural model.
module tb_alu_math_mc;
   import simple_processor_pkg::*;

   localparam int unsigned DW = 32;
   localparam int unsigned IW = 6;

   logic          clk_i = 1'b0;
   logic          rst_i;
   logic          valid_i;
   logic          ready_o;
   func_t         func_i;
   logic [DW-1:0] rs1_data_i;
   logic [DW-1:0] rs2_data_i;
   logic [IW-1:0] imm_i;
   logic          valid_o;
   logic          ready_i;
   logic [DW-1:0] result_o;
   logic          zero_o;
   logic          carry_o;
   logic          overflow_o;
   logic          err_o;

   alu_math_mc #(.DATA_WIDTH(DW), .IMM_WIDTH(IW)) dut (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .valid_i    (valid_i),
      .ready_o    (ready_o),
      .func_i     (func_i),
      .rs1_data_i (rs1_data_i),
      .rs2_data_i (rs2_data_i),
      .imm_i      (imm_i),
      .valid_o    (valid_o),
      .ready_i    (ready_i),
      .result_o   (result_o),
      .zero_o     (zero_o),
      .carry_o    (carry_o),
      .overflow_o (overflow_o),
      .err_o      (err_o)
   );

   always #5 clk_i = ~clk_i;

   typedef struct {
      logic [DW-1:0] res;
      logic          z;
      logic          c;
      logic          o;
      logic          e;
      int            due;
   } exp_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   int   cycle    = 0;
   bit   rand_ready = 1'b0;
   exp_t q[$];

   always @(posedge clk_i) cycle++;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cycle);
      end
   endtask

   // Reference: plain integer arithmetic on the request, no adder modelling.
   function automatic exp_t model(input func_t f, input logic [DW-1:0] a,
                                  input logic [DW-1:0] b, input logic [IW-1:0] imm);
      exp_t        m;
      logic [63:0] full;
      longint      sa, sb, ss;
      logic [DW-1:0] ub;
      m.res = '0; m.z = 1'b0; m.c = 1'b0; m.o = 1'b0; m.e = 1'b0; m.due = 0;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      case (f)
         FUNC_ADD, FUNC_ADDI: begin
            if (f == FUNC_ADDI) begin
               sb = longint'($signed(imm));
               ub = sb[DW-1:0];
            end else begin
               ub = b;
            end
            full  = {32'b0, a} + {32'b0, ub};
            ss    = sa + sb;
            m.res = full[DW-1:0];
            m.c   = full > 64'hFFFF_FFFF;
            m.o   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         FUNC_SUB: begin
            ss    = sa - sb;
            m.res = a - b;
            m.c   = a >= b;
            m.o   = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
         end
         FUNC_MUL: begin
            full  = {32'b0, a} * {32'b0, b};
            m.res = full[DW-1:0];
            m.c   = full[63:32] != 0;
            m.o   = m.c;
         end
         default: m.e = 1'b1;
      endcase
      m.z = (m.res == 0);
      return m;
   endfunction

   // Scoreboard: every negedge, outputs must match the oldest outstanding request.
   always @(negedge clk_i) begin
      if (rst_i) begin
         q.delete();
      end else begin
         if (q.size() == 0) begin
            chk("idle_valid", valid_o, 0);
            chk("idle_ready", ready_o, 1);
         end else if (cycle < q[0].due) begin
            chk("busy_valid", valid_o, 0);
            chk("busy_ready", ready_o, 0);
         end else begin
            chk("out_valid", valid_o, 1);
            chk("out_result", result_o, q[0].res);
            chk("out_zero", zero_o, q[0].z);
            chk("out_carry", carry_o, q[0].c);
            chk("out_ovf", overflow_o, q[0].o);
            chk("out_err", err_o, q[0].e);
            chk("out_ready", ready_o, ready_i);
            if (ready_i) void'(q.pop_front());
         end
         if (valid_i && ready_o) begin
            exp_t m;
            m = model(func_i, rs1_data_i, rs2_data_i, imm_i);
            m.due = cycle + 1 + ((func_i == FUNC_MUL) ? int'(DW) + 1 : 0);
            q.push_back(m);
         end
      end
   end

   always begin
      @(posedge clk_i);
      #1;
      if (rand_ready) ready_i = ($urandom % 3) != 0;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, n_checks %0d", n_checks);
      $fatal(1, "watchdog");
   end

   task automatic do_req(input func_t f, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         input logic [IW-1:0] imm);
      int w;
      func_i = f; rs1_data_i = a; rs2_data_i = b; imm_i = imm; valid_i = 1'b1;
      w = 0;
      @(negedge clk_i);
      while (!ready_o && w < 200) begin
         @(negedge clk_i);
         w++;
      end
      if (!ready_o) chk("accept_timeout", 0, 1);
      @(posedge clk_i);
      #1;
      valid_i    = 1'b0;
      rs1_data_i = $urandom;
      rs2_data_i = $urandom;
      imm_i      = IW'($urandom);
      func_i     = func_t'(3'($urandom));
   endtask

   task automatic await(output int lat);
      lat = 0;
      while (valid_o !== 1'b1 && lat < 100) begin
         @(posedge clk_i);
         #1;
         lat++;
      end
   endtask

   task automatic expect_out(input string name, input logic [DW-1:0] res,
                             input logic z, input logic c, input logic o, input logic e);
      chk({name, "_valid"}, valid_o, 1);
      chk({name, "_result"}, result_o, res);
      chk({name, "_zero"}, zero_o, z);
      chk({name, "_carry"}, carry_o, c);
      chk({name, "_ovf"}, overflow_o, o);
      chk({name, "_err"}, err_o, e);
   endtask

   function automatic logic [DW-1:0] rand_op();
      case ($urandom % 7)
         0: return '0;
         1: return 32'hFFFF_FFFF;
         2: return 32'h8000_0000;
         3: return 32'h7FFF_FFFF;
         4: return DW'($urandom % 16);
         5: return DW'($urandom % 65536);
         default: return DW'($urandom);
      endcase
   endfunction

   initial begin
      int     lat;
      logic   saw_valid;
      func_t  f;
      int     r;
      rst_i = 1'b1; valid_i = 1'b0; ready_i = 1'b1; func_i = FUNC_ADD;
      rs1_data_i = '0; rs2_data_i = '0; imm_i = '0;
      repeat (3) @(posedge clk_i);
      #1 rst_i = 1'b0;
      @(negedge clk_i);
      chk("reset_valid", valid_o, 0);
      chk("reset_ready", ready_o, 1);
      chk("reset_result", result_o, 0);
      chk("reset_flags", {zero_o, carry_o, overflow_o, err_o}, 0);
      @(posedge clk_i); #1;

      do_req(FUNC_ADD, 32'hFFFF_FFFF, 32'h1, '0);
      await(lat);
      chk("add_latency", lat, 0);
      expect_out("add_wrap", 32'h0, 1, 1, 0, 0);

      do_req(FUNC_ADDI, 32'h10, 32'hDEAD_BEEF, 6'b111110);
      await(lat);
      expect_out("addi_neg", 32'hE, 0, 1, 0, 0);

      do_req(FUNC_SUB, 32'h8000_0000, 32'h1, '0);
      await(lat);
      expect_out("sub_ovf", 32'h7FFF_FFFF, 0, 1, 1, 0);

      do_req(FUNC_MUL, 32'h0001_0000, 32'h0001_0000, '0);
      await(lat);
      chk("mul_latency", lat, DW + 1);
      expect_out("mul_hi", 32'h0, 1, 1, 1, 0);

      do_req(FUNC_MUL, 32'd7, 32'd6, '0);
      await(lat);
      chk("mul_latency2", lat, DW + 1);
      expect_out("mul_42", 32'd42, 0, 0, 0, 0);
      @(posedge clk_i); #1;

      // Backpressure: result must hold while the consumer stalls.
      ready_i = 1'b0;
      do_req(FUNC_ADD, 32'd5, 32'd9, '0);
      await(lat);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk_i);
         chk("bp_ready_low", ready_o, 0);
         expect_out("bp_hold", 32'd14, 0, 0, 0, 0);
      end
      @(posedge clk_i); #1;
      ready_i = 1'b1;
      func_i = FUNC_ADD; rs1_data_i = 32'd100; rs2_data_i = 32'd23; valid_i = 1'b1;
      @(negedge clk_i);
      chk("bp_ready_release", ready_o, 1);
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      expect_out("bp_next", 32'd123, 0, 0, 0, 0);

      // Reset in the middle of a multiply: the product is discarded.
      do_req(FUNC_MUL, 32'd1234, 32'd5678, '0);
      repeat (10) @(posedge clk_i);
      #1 rst_i = 1'b1;
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      chk("midrst_valid", valid_o, 0);
      chk("midrst_ready", ready_o, 1);
      chk("midrst_outs", {result_o, zero_o, carry_o, overflow_o, err_o}, 0);
      saw_valid = 1'b0;
      repeat (DW + 5) begin
         @(negedge clk_i);
         if (valid_o) saw_valid = 1'b1;
      end
      chk("midrst_no_result", saw_valid, 0);
      @(posedge clk_i); #1;
      do_req(FUNC_ADD, 32'd3, 32'd4, '0);
      await(lat);
      expect_out("post_rst_add", 32'd7, 0, 0, 0, 0);

      do_req(func_t'(3'd5), 32'h1234, 32'h5678, '0);
      await(lat);
      chk("inv_latency", lat, 0);
      expect_out("invalid", 32'h0, 1, 0, 0, 1);
      do_req(FUNC_ADD, 32'd1, 32'd1, '0);
      await(lat);
      expect_out("after_inv", 32'd2, 0, 0, 0, 0);

      // Randomized stream with random consumer stalls and issue gaps.
      rand_ready = 1'b1;
      for (int n = 0; n < 250; n++) begin
         r = int'($urandom % 10);
         if (r < 3)      f = FUNC_ADD;
         else if (r < 5) f = FUNC_ADDI;
         else if (r < 7) f = FUNC_SUB;
         else if (r < 9) f = FUNC_MUL;
         else            f = func_t'(3'(4 + $urandom % 4));
         do_req(f, rand_op(), rand_op(), IW'($urandom));
         repeat ($urandom % 3) begin
            @(posedge clk_i); #1;
         end
      end
      rand_ready = 1'b0;
      @(posedge clk_i); #2;
      ready_i = 1'b1;
      repeat (DW + 10) @(posedge clk_i);
      @(negedge clk_i);
      chk("drain_empty", q.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/alu_math_mc.md
# alu_math_mc

Multi-cycle, handshaked successor to the combinational math ALU of the simple processor. It is parametrised in data and immediate width. ADD, ADDI and SUB complete in one registered cycle. MUL uses an iterative shift-add engine. Every result carries zero/carry/overflow flags. It sits between register-file read and writeback, and uses valid/ready on both sides so the pipeline can stall around multi-cycle ops.

## Interface
- DATA_WIDTH, 32, operand/result width (≥ 8)
- IMM_WIDTH, 6, immediate width; sign-extended to DATA_WIDTH
- clk_i  in  1  clock; all state changes on rising edge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  request valid
- ready_o  out  1  block can accept a request this cycle
- func_i  in  func_t  operation (ADD, ADDI, SUB, MUL; other encodings invalid)
- rs1_data_i  in  DATA_WIDTH  operand A
- rs2_data_i  in  DATA_WIDTH  operand B (ignored for ADDI)
- imm_i  in  IMM_WIDTH  immediate (used only for ADDI)
- valid_o  out  1  result valid
- ready_i  in  1  consumer accepts result
- result_o  out  DATA_WIDTH  result
- zero_o, carry_o, overflow_o  out  1 each  flags for result_o
- err_o  out  1  request had an invalid func_i

## Operation
- Accept: a request is taken when valid_i && ready_o. Operands are captured on acceptance; later input changes have no effect.
- ready_o = (state==IDLE) && (!valid_o || ready_i). A new request may be accepted in the same cycle the previous result is consumed.
- States:
  - IDLE: accept ADD/ADDI/SUB/invalid, then load the output register and stay in IDLE. Accept MUL, then go to MUL_BUSY.
  - MUL_BUSY: one multiplier bit per cycle. Leave after DATA_WIDTH iterations, load the output register, then go to IDLE.
- ADD: rs1 + rs2.
- ADDI: rs1 + sext(imm_i).
- SUB: rs1 + ~rs2 + 1.
- Add/sub flags:
  - carry_o = carry-out of the DATA_WIDTH-bit adder. For SUB, 1 means no borrow (rs1 ≥ rs2 unsigned).
  - overflow_o = signed overflow.
  - zero_o = (result_o == 0).
- MUL: unsigned. result_o = low DATA_WIDTH bits of the product; carry_o = overflow_o = |high half; zero_o on the low half.
- Invalid func_i: result_o = 0, err_o = 1, zero_o = 1, carry_o = overflow_o = 0. Latency is 1.
- Output hold: result_o, the flags and err_o stay stable while valid_o && !ready_i. valid_o clears on a handshake unless a new result loads in the same edge.
- Reset: rst_i forces IDLE and valid_o = 0. result_o, all flags, err_o, and the multiplier accumulator/counter go to 0. ready_o is 1 the cycle after reset deasserts. An in-flight MUL is discarded and produces no result.

## Timing
- ADD/ADDI/SUB/invalid: accepted at edge N, valid_o high after edge N (latency 1). Back-to-back throughput is 1/cycle when ready_i = 1.
- MUL: accepted at edge N, valid_o high after edge N+DATA_WIDTH+1. ready_o is low throughout MUL_BUSY.
- ready_o depends combinationally on ready_i. No combinational path exists from valid_i to valid_o or from operands to result_o.
- Critical path: one DATA_WIDTH adder plus the flag logic before the output register.

## Structure
- simple_processor_pkg:
  - extend func_t with MUL;
  - add typedef alu_flags_t (zero, carry, overflow);
  - add a state enum alu_mc_state_t {IDLE, MUL_BUSY}.
- Sub-module alu_mul_iter: a shift-add multiplier.
  - Interface: start, operands, busy, done, 2·DATA_WIDTH product.
  - Counter width is $clog2(DATA_WIDTH+1).
- The top level holds the handshake, the add/sub datapath, the flag logic and the output register.

## Test plan
- ADD 0xFFFF_FFFF + 0x0000_0001, ready_i = 1: result 0x0000_0000, carry 1, zero 1, overflow 0, valid_o one cycle after accept.
- ADDI with rs1 = 0x0000_0010, imm = 6'b111110 (−2): result 0x0000_000E. Then SUB 0x8000_0000 − 0x0000_0001: result 0x7FFF_FFFF, overflow 1, carry 1.
- MUL 0x0001_0000 × 0x0001_0000: result 0, carry 1, overflow 1, zero 1, valid_o exactly DATA_WIDTH+1 cycles after accept. Then MUL 7 × 6: result 42, flags 0.
- Backpressure with ready_i = 0 for 5 cycles after an ADD: ready_o low, result_o held stable. When ready_i rises, a new valid_i request is accepted in the same cycle and its result appears on the next cycle.
- Assert rst_i for 1 cycle mid-MUL, at iteration 10: valid_o never rises for that MUL, all outputs 0, ready_o = 1 the next cycle. A subsequent ADD 3+4 yields 7.
- Invalid func_i encoding: err_o 1, result 0, zero 1, latency 1. The following valid ADD has err_o 0.
